display_scan_mux: RTL and testbench
===================================

DISPLAY_SCAN_MUX -- requirements
Module: display_scan_mux

Interface
REQ-001 Parameter: SCAN_DIV, default 50000, clk cycles per digit slot; legal range 2..65535.
REQ-002 Port: clk  input  1  single system clock; all logic on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: load  input  1  single-cycle strobe; capture value_in this cycle.
REQ-005 Port: value_in  input  16  four BCD nibbles; [15:12]=digit3 (leftmost) ... [3:0]=digit0 (rightmost).
REQ-006 Port: blank_lz  input  1  1 = leading-zero blanking enabled; sampled every cycle.
REQ-007 Port: digit_out  output  4  BCD nibble for the active slot; feeds the BCD-to-7-segment decoder d_in.
REQ-008 Port: an_n  output  4  active-low anode enables; bit i low = digit i lit.
REQ-009 Port: err  output  1  high while the held value contains a nibble > 9.

Function
REQ-010 Internal 16-bit hold register SHALL capture value_in on any clk edge with load=1 and SHALL otherwise hold.
REQ-011 Prescaler SHALL count 0..SCAN_DIV-1, wrap to 0, and assert a one-cycle tick when at SCAN_DIV-1.
REQ-012 Scan FSM states SCAN0..SCAN3 (active slot index 0..3) SHALL advance SCAN0->SCAN1->SCAN2->SCAN3->SCAN0 on tick only; no other transitions.
REQ-013 digit_out and an_n SHALL be registered, computed each cycle from the current FSM state, hold register and blank_lz; latency one cycle from any change of those.
REQ-014 Unblanked slot i: digit_out = hold nibble i; an_n = all ones except bit i = 0.
REQ-015 Slot i (i = 1..3) SHALL be blanked when blank_lz=1 and hold nibbles i..3 are all zero; digit 0 is never blanked.
REQ-016 Blanked slot: an_n = 4'b1111, digit_out = 4'h0.
REQ-017 Nibbles > 9 SHALL be passed unmodified to digit_out; they SHALL be treated as non-zero for blanking.
REQ-018 err SHALL update one cycle after a load: 1 if any loaded nibble > 9, else 0; err SHALL hold between loads.
REQ-019 Load and tick in the same cycle: both SHALL take effect; the next output cycle SHALL show the new FSM state with the new value.
REQ-020 Back-to-back loads: the last captured value SHALL win; no load SHALL be dropped or delayed.
REQ-021 At most one an_n bit SHALL be low in any cycle.

Reset
REQ-022 reset=1 on a clk edge SHALL set: prescaler 0, FSM SCAN0, hold register 16'h0000, digit_out 4'h0, an_n 4'b1111, err 0.
REQ-023 reset SHALL override load and tick in the same cycle.
REQ-024 A mid-scan reset SHALL restart the scan at SCAN0 with the full SCAN_DIV period.
REQ-025 First cycle after reset release: an_n = 4'b1110, digit_out = 4'h0.

Structure
REQ-026 A shared package SHALL hold: SCAN_DIV default, NUM_DIGITS = 4, AN_ALL_OFF = 4'b1111, scan-state encoding SCAN0..SCAN3, BCD_MAX = 9.
REQ-027 The prescaler SHALL be one sub-module, scan_prescaler (parameter SCAN_DIV; ports clk, reset, tick); the remaining logic stays flat in display_scan_mux.

Verification (SCAN_DIV=4)
REQ-028 Reset, then run 16 cycles with no load -> an_n sequence 1110,1101,1011,0111, each held 4 cycles; digit_out always 0.
REQ-029 load value_in=16'h1234, blank_lz=0 -> digit_out cycles 4,3,2,1 in step with an_n 1110,1101,1011,0111; err=0.
REQ-030 load 16'h0042, blank_lz=1 -> slots 0,1 show 2,4; slots 2,3 give an_n=1111 and digit_out=0. Then blank_lz=0 -> slots 2,3 show 0 with their anode low.
REQ-031 load 16'h0A05 -> err=1 next cycle; slot 2 digit_out=4'hA and is not blanked with blank_lz=1. Then load 16'h0005 -> err=0.
REQ-032 Assert reset during SCAN2 with hold=16'h9876 -> next cycle an_n=1111, err=0; after release, scan restarts at SCAN0 with digit_out=0.
REQ-033 Assert load in the same cycle as a tick -> next cycle shows the new slot's nibble from the new value; checker confirms REQ-021 on every cycle.

Source files
------------

// File: rtl/display_scan_mux_pkg.sv
// Shared constants, scan-state encoding and BCD helper for the multiplexed
// four-digit display scanner.
package display_scan_mux_pkg;

  localparam int unsigned SCAN_DIV_DEFAULT = 50000;
  localparam int unsigned NUM_DIGITS       = 4;
  localparam logic [3:0]  AN_ALL_OFF       = 4'b1111;
  localparam logic [3:0]  BCD_MAX          = 4'd9;

  typedef enum logic [1:0] {
    SCAN0 = 2'd0,
    SCAN1 = 2'd1,
    SCAN2 = 2'd2,
    SCAN3 = 2'd3
  } scan_state_t;

  // True when any nibble of the word lies outside the BCD range.
  function automatic logic has_non_bcd(input logic [4*NUM_DIGITS-1:0] value);
    logic found;
    found = 1'b0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (value[4*i +: 4] > BCD_MAX) begin
        found = 1'b1;
      end
    end
    return found;
  endfunction

endpackage

// File: rtl/display_scan_mux_prescaler.sv
// Free-running divider: counts 0..SCAN_DIV-1 and pulses tick for one cycle
// while the count sits at its terminal value.
module scan_prescaler
  import display_scan_mux_pkg::*;
#(
  parameter int unsigned SCAN_DIV = SCAN_DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam logic [15:0] LAST_COUNT = 16'(SCAN_DIV - 1);

  logic [15:0] count_reg;
  logic [15:0] count_next;

  assign tick = (count_reg == LAST_COUNT);

  always_comb begin
    count_next = count_reg + 16'd1;
    if (tick) begin
      count_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/display_scan_mux.sv
// Four-digit time-multiplexed BCD display driver with leading-zero blanking
// and a sticky-until-next-load non-BCD error flag.
module display_scan_mux
  import display_scan_mux_pkg::*;
#(
  parameter int unsigned SCAN_DIV = SCAN_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] value_in,
  input  logic        blank_lz,
  output logic [3:0]  digit_out,
  output logic [3:0]  an_n,
  output logic        err
);

  logic                  tick;
  scan_state_t           state_reg, state_next;
  logic [15:0]           hold_reg;
  logic [3:0]            digit_reg, digit_next;
  logic [3:0]            an_reg, an_next;
  logic                  err_reg;
  logic [1:0]            slot_idx;
  logic [NUM_DIGITS-1:0] upper_zero;

  scan_prescaler #(.SCAN_DIV(SCAN_DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // upper_zero[i]: slot i may be blanked because it and every slot to its
  // left hold zero. Digit 0 always shows, so its bit is tied low.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
      if (gi == 0) begin : g_units
        assign upper_zero[gi] = 1'b0;
      end else begin : g_upper
        assign upper_zero[gi] = (hold_reg[4*NUM_DIGITS-1 : 4*gi] == '0);
      end
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    if (tick) begin
      case (state_reg)
        SCAN0:   state_next = SCAN1;
        SCAN1:   state_next = SCAN2;
        SCAN2:   state_next = SCAN3;
        default: state_next = SCAN0;
      endcase
    end
  end

  assign slot_idx = state_reg;

  always_comb begin
    digit_next = hold_reg[{slot_idx, 2'b00} +: 4];
    an_next    = ~(4'b0001 << slot_idx);
    if (blank_lz && upper_zero[slot_idx]) begin
      digit_next = 4'h0;
      an_next    = AN_ALL_OFF;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= SCAN0;
      hold_reg  <= 16'h0000;
      digit_reg <= 4'h0;
      an_reg    <= AN_ALL_OFF;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      digit_reg <= digit_next;
      an_reg    <= an_next;
      if (load) begin
        hold_reg <= value_in;
        err_reg  <= has_non_bcd(value_in);
      end
    end
  end

  assign digit_out = digit_reg;
  assign an_n      = an_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_display_scan_mux.sv
// Directed and randomized bench for display_scan_mux (SCAN_DIV=4), checked
// against a slot-arithmetic reference model.
module tb_display_scan_mux;

  localparam int SCAN_DIV = 4;

  logic        clk;
  logic        reset;
  logic        load;
  logic [15:0] value_in;
  logic        blank_lz;
  logic [3:0]  digit_out;
  logic [3:0]  an_n;
  logic        err;

  int checks;
  int errors;

  // Reference model state: edges since reset release, held value, error flag.
  int          m_cycles;
  logic [15:0] m_hold;
  logic        m_err;

  display_scan_mux #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .value_in  (value_in),
    .blank_lz  (blank_lz),
    .digit_out (digit_out),
    .an_n      (an_n),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic any_gt9(input logic [15:0] v);
    for (int i = 0; i < 4; i++) begin
      if (((v >> (4 * i)) & 16'hF) > 16'd9) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int cur_slot();
    return (m_cycles / SCAN_DIV) % 4;
  endfunction

  // One clock: apply inputs, predict, clock, check, advance the model.
  task automatic cycle(input logic rst, input logic ld, input logic [15:0] v,
                       input logic bl, input string tag);
    logic [3:0] exp_dig;
    logic [3:0] exp_an;
    logic       exp_err;
    int         slot;
    logic [15:0] upper;
    reset    = rst;
    load     = ld;
    value_in = v;
    blank_lz = bl;
    if (rst) begin
      exp_dig = 4'h0;
      exp_an  = 4'b1111;
      exp_err = 1'b0;
    end else begin
      slot  = cur_slot();
      upper = m_hold >> (4 * slot);
      if (bl && slot > 0 && upper == 16'h0) begin
        exp_dig = 4'h0;
        exp_an  = 4'b1111;
      end else begin
        exp_dig = upper[3:0];
        exp_an  = 4'b1111 & ~(4'b0001 << slot);
      end
      exp_err = ld ? any_gt9(v) : m_err;
    end
    @(posedge clk);
    #1;
    if (rst) begin
      m_hold   = 16'h0;
      m_err    = 1'b0;
      m_cycles = 0;
    end else begin
      if (ld) m_hold = v;
      m_err    = exp_err;
      m_cycles = m_cycles + 1;
    end
    checks++;
    assert (digit_out === exp_dig) else begin
      errors++;
      $error("FAIL %s digit_out got %h expected %h", tag, digit_out, exp_dig);
    end
    checks++;
    assert (an_n === exp_an) else begin
      errors++;
      $error("FAIL %s an_n got %b expected %b", tag, an_n, exp_an);
    end
    checks++;
    assert (err === exp_err) else begin
      errors++;
      $error("FAIL %s err got %b expected %b", tag, err, exp_err);
    end
    checks++;
    assert ($countones(~an_n) <= 1) else begin
      errors++;
      $error("FAIL %s onehot an_n got %b expected at most one low bit", tag, an_n);
    end
  endtask

  task automatic idle(input int n, input logic bl, input string tag);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 16'h0, bl, tag);
  endtask

  initial begin
    logic [15:0] rv;
    logic [15:0] masks [4];
    checks   = 0;
    errors   = 0;
    m_cycles = 0;
    m_hold   = 16'h0;
    m_err    = 1'b0;
    reset    = 1'b1;
    load     = 1'b0;
    value_in = 16'h0;
    blank_lz = 1'b0;
    masks[0] = 16'h000F;
    masks[1] = 16'h00FF;
    masks[2] = 16'h0FFF;
    masks[3] = 16'hFFFF;

    // Reset state, then one full scan of an all-zero value.
    cycle(1'b1, 1'b0, 16'h0, 1'b0, "reset");
    cycle(1'b1, 1'b1, 16'hFFFF, 1'b0, "reset_over_load");
    idle(16, 1'b0, "scan_zero");

    cycle(1'b0, 1'b1, 16'h1234, 1'b0, "load_1234");
    idle(16, 1'b0, "scan_1234");

    cycle(1'b0, 1'b1, 16'h0042, 1'b1, "load_0042");
    idle(16, 1'b1, "blank_0042");
    idle(16, 1'b0, "noblank_0042");

    cycle(1'b0, 1'b1, 16'h0A05, 1'b1, "load_0A05");
    idle(16, 1'b1, "hex_0A05");
    cycle(1'b0, 1'b1, 16'h0005, 1'b1, "load_0005");
    idle(16, 1'b1, "blank_0005");

    // Mid-scan reset during SCAN2.
    cycle(1'b0, 1'b1, 16'h9876, 1'b0, "load_9876");
    while (cur_slot() != 2) cycle(1'b0, 1'b0, 16'h0, 1'b0, "to_scan2");
    cycle(1'b0, 1'b0, 16'h0, 1'b0, "in_scan2");
    cycle(1'b1, 1'b0, 16'h0, 1'b0, "midscan_reset");
    idle(20, 1'b0, "after_reset");

    // Load coinciding with the prescaler tick.
    cycle(1'b0, 1'b1, 16'h5678, 1'b0, "load_5678");
    while ((m_cycles % SCAN_DIV) != SCAN_DIV - 1)
      cycle(1'b0, 1'b0, 16'h0, 1'b0, "to_tick");
    cycle(1'b0, 1'b1, 16'h4321, 1'b0, "load_on_tick");
    idle(8, 1'b0, "after_tick_load");

    // Back-to-back loads: last one wins.
    cycle(1'b0, 1'b1, 16'h1111, 1'b0, "b2b_a");
    cycle(1'b0, 1'b1, 16'hB222, 1'b0, "b2b_b");
    cycle(1'b0, 1'b1, 16'h0333, 1'b1, "b2b_c");
    idle(16, 1'b1, "b2b_scan");

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      rv = 16'($urandom) & masks[$urandom_range(0, 3)];
      cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0), rv,
            1'($urandom_range(0, 1)), "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
